reg_wr_arb: RTL and testbench

REG_WR_ARB -- requirements
Module: reg_wr_arb

---
 rtl/reg_wr_arb_if.sv | 41 ++++
 rtl/reg_wr_arb.sv | 157 +++++++++++++++
 tb/tb_reg_wr_arb.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_wr_arb_if.sv
// Bundles the requester-side write handshake, the register-file write port,
// the decode-stage hazard lookup and flush/busy.
// Modport master: driven by the requesters, decode and the pipeline controller.
// Modport slave: driven by the arbiter.
//   flush                 : synchronous discard of all pending writes
//   req_valid/ready       : per-requester handshake
//   req_addr/data/imm     : per-requester write payload (imm selects RIM)
//   write_en/imm, waddr, data_in : register file write port
//   raddrA/B, hazardA/B   : read addresses under decode and their hazard flags
//   busy                  : any write still pending
interface reg_wr_arb_if #(
    parameter int unsigned W = 8,
    parameter int unsigned D = 3,
    parameter int unsigned N = 3
);
    logic                   flush;
    logic [N-1:0]           req_valid;
    logic [N-1:0]           req_ready;
    logic [N-1:0][D-1:0]    req_addr;
    logic [N-1:0][W-1:0]    req_data;
    logic [N-1:0]           req_imm;
    logic                   write_en;
    logic                   write_imm;
    logic [D-1:0]           waddr;
    logic [W-1:0]           data_in;
    logic [D-1:0]           raddrA;
    logic [D-1:0]           raddrB;
    logic                   hazardA;
    logic                   hazardB;
    logic                   busy;

    modport master (
        output flush, req_valid, req_addr, req_data, req_imm, raddrA, raddrB,
        input  req_ready, write_en, write_imm, waddr, data_in, hazardA, hazardB, busy
    );

    modport slave (
        input  flush, req_valid, req_addr, req_data, req_imm, raddrA, raddrB,
        output req_ready, write_en, write_imm, waddr, data_in, hazardA, hazardB, busy
    );
endinterface

// File: rtl/reg_wr_arb.sv
// Register-file write arbiter: one buffer entry per requester, round-robin
// grant of one entry per cycle into a registered write stage, plus
// combinational read-after-write hazard detection for the decode stage.
// Ports:
//   CLK    : clock, all state on rising edge
//   RESETn : asynchronous active-low reset
//   bus    : reg_wr_arb_if slave (handshakes, write port, hazards, busy, flush)
module reg_wr_arb #(
    parameter int unsigned W = 8,
    parameter int unsigned D = 3,
    parameter int unsigned N = 3
) (
    input  logic          CLK,
    input  logic          RESETn,
    reg_wr_arb_if.slave   bus
);

    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

    // Per-requester buffer entries
    logic [N-1:0]           r_v;
    logic [N-1:0][D-1:0]    r_addr;
    logic [N-1:0][W-1:0]    r_data;
    logic [N-1:0]           r_imm;
    logic [PW-1:0]          r_ptr;

    // Registered write stage
    logic                   r_we;
    logic                   r_wimm;
    logic [D-1:0]           r_waddr;
    logic [W-1:0]           r_wdata;

    // Next-state values
    logic [N-1:0]           w_v_nxt;
    logic [N-1:0][D-1:0]    w_addr_nxt;
    logic [N-1:0][W-1:0]    w_data_nxt;
    logic [N-1:0]           w_imm_nxt;
    logic [PW-1:0]          w_ptr_nxt;
    logic                   w_we_nxt;
    logic                   w_wimm_nxt;
    logic [D-1:0]           w_waddr_nxt;
    logic [W-1:0]           w_wdata_nxt;

    logic                   w_gnt;
    logic [PW-1:0]          w_gidx;
    logic [N-1:0]           w_ready;
    logic [N-1:0]           w_hs;
    logic                   w_haz_a;
    logic                   w_haz_b;

    // Round-robin search starting at r_ptr; flush suppresses any grant
    always_comb begin : arb
        logic [PW-1:0] idx;
        w_gnt  = 1'b0;
        w_gidx = '0;
        idx    = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = PW'((32'(r_ptr) + k) % N);
            if (!w_gnt && !bus.flush && r_v[idx]) begin
                w_gnt  = 1'b1;
                w_gidx = idx;
            end
        end
    end

    // Ready depends only on buffer state, grant and flush, never on req_valid
    always_comb begin
        w_ready = '0;
        for (int unsigned i = 0; i < N; i++) begin
            w_ready[i] = !bus.flush && (!r_v[i] || (w_gnt && (w_gidx == PW'(i))));
        end
    end

    assign w_hs = bus.req_valid & w_ready;

    // Next-state: buffer load/clear, pointer advance, write stage
    always_comb begin
        w_v_nxt     = r_v;
        w_addr_nxt  = r_addr;
        w_data_nxt  = r_data;
        w_imm_nxt   = r_imm;
        w_ptr_nxt   = r_ptr;
        w_we_nxt    = 1'b0;
        w_wimm_nxt  = 1'b0;
        w_waddr_nxt = r_waddr;
        w_wdata_nxt = r_wdata;

        if (bus.flush) begin
            w_v_nxt = '0;
        end else begin
            for (int unsigned i = 0; i < N; i++) begin
                // A reload on the granted port wins over the clear
                if (w_hs[i]) begin
                    w_v_nxt[i]    = 1'b1;
                    w_addr_nxt[i] = bus.req_addr[i];
                    w_data_nxt[i] = bus.req_data[i];
                    w_imm_nxt[i]  = bus.req_imm[i];
                end else if (w_gnt && (w_gidx == PW'(i))) begin
                    w_v_nxt[i] = 1'b0;
                end
            end
        end

        if (w_gnt) begin
            w_ptr_nxt   = (w_gidx == PW'(N - 1)) ? '0 : w_gidx + PW'(1);
            w_we_nxt    = 1'b1;
            w_wimm_nxt  = r_imm[w_gidx];
            w_waddr_nxt = r_imm[w_gidx] ? '0 : r_addr[w_gidx];
            w_wdata_nxt = r_data[w_gidx];
        end
    end

    // State register
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_v     <= '0;
            r_addr  <= '0;
            r_data  <= '0;
            r_imm   <= '0;
            r_ptr   <= '0;
            r_we    <= 1'b0;
            r_wimm  <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            r_v     <= w_v_nxt;
            r_addr  <= w_addr_nxt;
            r_data  <= w_data_nxt;
            r_imm   <= w_imm_nxt;
            r_ptr   <= w_ptr_nxt;
            r_we    <= w_we_nxt;
            r_wimm  <= w_wimm_nxt;
            r_waddr <= w_waddr_nxt;
            r_wdata <= w_wdata_nxt;
        end
    end

    // Hazard: match against pending non-RIM buffers and the active write stage
    always_comb begin
        w_haz_a = r_we && !r_wimm && (r_waddr == bus.raddrA);
        w_haz_b = r_we && !r_wimm && (r_waddr == bus.raddrB);
        for (int unsigned i = 0; i < N; i++) begin
            if (r_v[i] && !r_imm[i] && (r_addr[i] == bus.raddrA)) w_haz_a = 1'b1;
            if (r_v[i] && !r_imm[i] && (r_addr[i] == bus.raddrB)) w_haz_b = 1'b1;
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.write_en  = r_we;
    assign bus.write_imm = r_wimm;
    assign bus.waddr     = r_waddr;
    assign bus.data_in   = r_wdata;
    assign bus.hazardA   = w_haz_a;
    assign bus.hazardB   = w_haz_b;
    assign bus.busy      = (|r_v) | r_we;

endmodule

// File: tb/tb_reg_wr_arb.sv
// Scoreboard bench for reg_wr_arb: directed writes push expected commits,
// a negedge monitor pops and compares every write_en cycle.
module tb_reg_wr_arb;

    localparam int unsigned W = 8;
    localparam int unsigned D = 3;
    localparam int unsigned N = 3;

    logic CLK    = 1'b0;
    logic RESETn = 1'b0;

    reg_wr_arb_if #(.W(W), .D(D), .N(N)) bus ();

    reg_wr_arb #(.W(W), .D(D), .N(N)) dut (
        .CLK    (CLK),
        .RESETn (RESETn),
        .bus    (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic         imm;
        logic [D-1:0] addr;
        logic [W-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic wr_t mk(input logic imm, input logic [D-1:0] a, input logic [W-1:0] d);
        wr_t e;
        e.imm  = imm;
        e.addr = a;
        e.data = d;
        return e;
    endfunction

    // Monitor: every committed write must match the head of the queue
    always @(negedge CLK) begin : mon
        wr_t e;
        if (RESETn && bus.write_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got waddr=%0h data=%0h imm=%0b, expected no write",
                         bus.waddr, bus.data_in, bus.write_imm);
            end else begin
                e = exp_q.pop_front();
                chk("commit_imm",  32'(bus.write_imm), 32'(e.imm));
                chk("commit_addr", 32'(bus.waddr),     32'(e.addr));
                chk("commit_data", 32'(bus.data_in),   32'(e.data));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        bus.flush     = 1'b0;
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        bus.req_imm   = '0;
        bus.raddrA    = '0;
        bus.raddrB    = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        RESETn = 1'b0;
        repeat (2) @(posedge CLK);
        #1 RESETn = 1'b1;
    endtask

    initial begin
        int  cnt0;
        int  cnt1;
        logic prev0;
        logic prev1;
        logic hs0;
        logic hs1;

        // Reset state
        do_reset();
        @(negedge CLK);
        chk("rst_ready",   32'(bus.req_ready), 32'h7);
        chk("rst_hazardA", 32'(bus.hazardA),   32'h0);
        chk("rst_hazardB", 32'(bus.hazardB),   32'h0);
        chk("rst_busy",    32'(bus.busy),      32'h0);
        chk("rst_we",      32'(bus.write_en),  32'h0);
        chk("rst_waddr",   32'(bus.waddr),     32'h0);
        tick();

        // Single write: port0 addr 3 data 5A, write_en in the cycle after the second edge
        bus.req_valid   = 3'b001;
        bus.req_addr[0] = 3'd3;
        bus.req_data[0] = 8'h5A;
        exp_q.push_back(mk(1'b0, 3'd3, 8'h5A));
        tick();
        bus.req_valid = '0;
        @(negedge CLK);
        chk("single_we_e0",   32'(bus.write_en), 32'h0);
        chk("single_busy_e0", 32'(bus.busy),     32'h1);
        @(negedge CLK);
        chk("single_we_e1",   32'(bus.write_en), 32'h1);
        @(negedge CLK);
        chk("single_we_e2",   32'(bus.write_en), 32'h0);
        chk("single_busy_e2", 32'(bus.busy),     32'h0);
        tick();

        // Contention: all three ports at once from ptr=0, port2 targets RIM
        do_reset();
        bus.req_valid   = 3'b111;
        bus.req_addr[0] = 3'd1; bus.req_data[0] = 8'h11;
        bus.req_addr[1] = 3'd2; bus.req_data[1] = 8'h22;
        bus.req_addr[2] = 3'd7; bus.req_data[2] = 8'h33;
        bus.req_imm     = 3'b100;
        bus.raddrA      = 3'd7;
        bus.raddrB      = 3'd2;
        exp_q.push_back(mk(1'b0, 3'd1, 8'h11));
        exp_q.push_back(mk(1'b0, 3'd2, 8'h22));
        exp_q.push_back(mk(1'b1, 3'd0, 8'h33));
        tick();
        bus.req_valid = '0;
        bus.req_imm   = '0;
        @(negedge CLK);
        chk("cont_hazA_imm_ignored", 32'(bus.hazardA),   32'h0);
        chk("cont_hazB",             32'(bus.hazardB),   32'h1);
        chk("cont_ready_e0",         32'(bus.req_ready), 32'h1);
        @(negedge CLK);
        chk("cont_ready_e1",         32'(bus.req_ready), 32'h3);
        @(negedge CLK);
        chk("cont_ready_e2",         32'(bus.req_ready), 32'h7);
        @(negedge CLK);
        chk("cont_hazA_rim_write",   32'(bus.hazardA),   32'h0);
        tick();
        tick();
        bus.raddrA = '0;
        bus.raddrB = '0;

        // Fairness: ports 0 and 1 every cycle; ptr must be back at 0 here
        for (int k = 0; k < 6; k++) begin
            exp_q.push_back(mk(1'b0, 3'd1, W'(8'h40 + k)));
            if (k < 5) exp_q.push_back(mk(1'b0, 3'd2, W'(8'h80 + k)));
        end
        cnt0  = 0;
        cnt1  = 0;
        prev0 = 1'b1;
        prev1 = 1'b1;
        bus.req_addr[0] = 3'd1;
        bus.req_addr[1] = 3'd2;
        for (int c = 0; c < 10; c++) begin
            bus.req_valid   = 3'b011;
            bus.req_data[0] = W'(8'h40 + cnt0);
            bus.req_data[1] = W'(8'h80 + cnt1);
            @(negedge CLK);
            hs0 = bus.req_ready[0];
            hs1 = bus.req_ready[1];
            chk("fair_ready0_gap", 32'(prev0 | hs0), 32'h1);
            chk("fair_ready1_gap", 32'(prev1 | hs1), 32'h1);
            prev0 = hs0;
            prev1 = hs1;
            tick();
            if (hs0) cnt0++;
            if (hs1) cnt1++;
        end
        bus.req_valid = '0;
        chk("fair_accepts0", 32'(cnt0), 32'd6);
        chk("fair_accepts1", 32'(cnt1), 32'd5);
        repeat (4) tick();

        // Hazard: port1 pending addr 5
        do_reset();
        bus.req_valid   = 3'b010;
        bus.req_addr[1] = 3'd5;
        bus.req_data[1] = 8'h55;
        bus.raddrA      = 3'd5;
        bus.raddrB      = 3'd4;
        exp_q.push_back(mk(1'b0, 3'd5, 8'h55));
        tick();
        bus.req_valid = '0;
        @(negedge CLK);
        chk("haz_A_buffered", 32'(bus.hazardA), 32'h1);
        chk("haz_B_buffered", 32'(bus.hazardB), 32'h0);
        @(negedge CLK);
        chk("haz_A_wstage",   32'(bus.hazardA), 32'h1);
        chk("haz_B_wstage",   32'(bus.hazardB), 32'h0);
        @(negedge CLK);
        chk("haz_A_committed", 32'(bus.hazardA), 32'h0);
        tick();

        // Flush with three buffers valid
        do_reset();
        bus.req_valid   = 3'b111;
        bus.req_addr[0] = 3'd1; bus.req_data[0] = 8'h01;
        bus.req_addr[1] = 3'd2; bus.req_data[1] = 8'h02;
        bus.req_addr[2] = 3'd3; bus.req_data[2] = 8'h03;
        tick();
        bus.req_valid = 3'b111;
        bus.flush     = 1'b1;
        @(negedge CLK);
        chk("flush_ready_low", 32'(bus.req_ready), 32'h0);
        chk("flush_busy_pre",  32'(bus.busy),      32'h1);
        tick();
        bus.flush     = 1'b0;
        bus.req_valid = '0;
        @(negedge CLK);
        chk("flush_we",    32'(bus.write_en),  32'h0);
        chk("flush_busy",  32'(bus.busy),      32'h0);
        chk("flush_ready", 32'(bus.req_ready), 32'h7);
        repeat (3) tick();

        // Async reset while write_en=1; port1's pending write must be discarded
        do_reset();
        bus.req_valid   = 3'b011;
        bus.req_addr[0] = 3'd1; bus.req_data[0] = 8'hA1;
        bus.req_addr[1] = 3'd2; bus.req_data[1] = 8'hB2;
        exp_q.push_back(mk(1'b0, 3'd1, 8'hA1));
        tick();
        bus.req_valid = '0;
        @(negedge CLK);
        chk("areset_we_e0", 32'(bus.write_en), 32'h0);
        @(negedge CLK);
        chk("areset_we_e1", 32'(bus.write_en), 32'h1);
        #2 RESETn = 1'b0;
        #1;
        chk("areset_we_now",   32'(bus.write_en),  32'h0);
        chk("areset_busy_now", 32'(bus.busy),      32'h0);
        chk("areset_ready",    32'(bus.req_ready), 32'h7);
        chk("areset_waddr",    32'(bus.waddr),     32'h0);
        chk("areset_data",     32'(bus.data_in),   32'h0);
        @(posedge CLK);
        #1 RESETn = 1'b1;
        @(negedge CLK);
        chk("areset_we_after",   32'(bus.write_en), 32'h0);
        chk("areset_busy_after", 32'(bus.busy),     32'h0);
        // ptr back at 0: ports 0 and 2 together must grant port 0 first
        tick();
        bus.req_valid   = 3'b101;
        bus.req_addr[0] = 3'd4; bus.req_data[0] = 8'hC4;
        bus.req_addr[2] = 3'd6; bus.req_data[2] = 8'hC6;
        exp_q.push_back(mk(1'b0, 3'd4, 8'hC4));
        exp_q.push_back(mk(1'b0, 3'd6, 8'hC6));
        tick();
        bus.req_valid = '0;
        repeat (5) tick();

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
